// File: rtl/kronos_mem_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and LSU data, with a bus-timeout watchdog.
// Optional: define KRONOS_ARB_ROUND_ROBIN_EN to break IDLE ties against the last owner instead of favouring data.
module kronos_mem_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int TCW     = 9
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_wr_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;
  typedef enum logic {OWN_INSTR = 1'b0, OWN_DATA = 1'b1} owner_t;

  localparam bit             TMO_EN   = (TIMEOUT != 0);
  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  owner_t         last_q;
  logic [TCW-1:0] tmo_cnt_q;
  logic           load_i, load_d, done, tmo_hit, tie_to_data;

  // A genuine mem_ack in the last allowed cycle wins over the watchdog.
  assign tmo_hit = TMO_EN && (state_q != IDLE) && !mem_ack && (tmo_cnt_q == TMO_LAST);
  assign mem_req = (state_q != IDLE);

`ifdef KRONOS_ARB_ROUND_ROBIN_EN
  assign tie_to_data = (last_q == OWN_INSTR);
`else
  assign tie_to_data = 1'b1;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    state_d      = state_q;
    load_i       = 1'b0;
    load_d       = 1'b0;
    done         = 1'b0;
    instr_ack    = 1'b0;
    data_ack     = 1'b0;
    instr_data   = '0;
    data_rd_data = '0;
    bus_error    = tmo_hit;
    unique case (state_q)
      IDLE: begin
        if (data_req && (!instr_req || tie_to_data)) load_d = 1'b1;
        else if (instr_req)                          load_i = 1'b1;
      end
      GNT_I: begin
        done      = mem_ack || tmo_hit;
        instr_ack = done;
        if (mem_ack) instr_data = mem_rd_data;
        // Owner's own req is ignored on completion; hand over directly if the other side waits.
        if (done) begin
          if (data_req) load_d  = 1'b1;
          else          state_d = IDLE;
        end
      end
      GNT_D: begin
        done     = mem_ack || tmo_hit;
        data_ack = done;
        if (mem_ack) data_rd_data = mem_rd_data;
        if (done) begin
          if (instr_req) load_i  = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_i) state_d = GNT_I;
    if (load_d) state_d = GNT_D;
  end

  // NOTE: every register here, payload included, has an async reset value; no storage array is involved.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q     <= IDLE;
      last_q      <= OWN_INSTR;
      tmo_cnt_q   <= '0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_mask <= '0;
      mem_wr_en   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      if (done) last_q <= (state_q == GNT_D) ? OWN_DATA : OWN_INSTR;

      if (load_i) begin
        mem_addr    <= instr_addr;
        mem_wr_data <= '0;
        mem_wr_mask <= '0;
        mem_wr_en   <= 1'b0;
      end else if (load_d) begin
        mem_addr    <= data_addr;
        mem_wr_data <= data_wr_data;
        mem_wr_mask <= data_wr_mask;
        mem_wr_en   <= data_wr_en;
      end else if (state_d == IDLE) begin
        mem_addr    <= '0;
        mem_wr_data <= '0;
        mem_wr_mask <= '0;
        mem_wr_en   <= 1'b0;
      end

      if (load_i || load_d || state_d == IDLE) tmo_cnt_q <= '0;
      else if (!mem_ack)                       tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters/memory against a transaction-level model.
module tb_kronos_mem_arbiter;
  localparam int TIMEOUT = 4;
  localparam int TCW     = 3;

  logic        clk = 1'b0;
  logic        rstz;
  logic [31:0] instr_addr, data_addr, data_wr_data, mem_rd_data;
  logic [3:0]  data_wr_mask;
  logic        instr_req, data_req, data_wr_en, mem_ack;
  logic        instr_ack, data_ack, mem_wr_en, mem_req, bus_error;
  logic [31:0] instr_data, data_rd_data, mem_addr, mem_wr_data;
  logic [3:0]  mem_wr_mask;

  int checks = 0;
  int failures = 0;

  kronos_mem_arbiter #(.TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack), .instr_data(instr_data),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_wr_mask(data_wr_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack), .data_rd_data(data_rd_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask), .mem_wr_en(mem_wr_en),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 fetch, 2 data), cycles spent unacked, last owner, granted payload.
  int          m_owner, m_age, m_last;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_mask;
  logic        m_wen;
  logic        e_iack, e_dack;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_last = 1;
    m_addr = '0; m_wdata = '0; m_mask = '0; m_wen = 1'b0;
    e_iack = 1'b0; e_dack = 1'b0;
  endtask

  task automatic grant(input int who);
    m_owner = who;
    m_age   = 0;
    if (who == 1) begin
      m_addr = instr_addr; m_wdata = '0; m_mask = '0; m_wen = 1'b0;
    end else begin
      m_addr = data_addr; m_wdata = data_wr_data; m_mask = data_wr_mask; m_wen = data_wr_en;
    end
  endtask

  // One clock cycle: inputs already driven after a negedge; check, advance the model, move to next negedge.
  task automatic step();
    logic hit, tmo, fin;
    int   other;
    #1;
    hit    = (m_owner != 0) && mem_ack;
    tmo    = (m_owner != 0) && !mem_ack && (m_age == TIMEOUT - 1);
    fin    = hit || tmo;
    e_iack = (m_owner == 1) && fin;
    e_dack = (m_owner == 2) && fin;
    check("mem_req", 32'(mem_req), 32'(m_owner != 0));
    if (m_owner != 0) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wr_data", mem_wr_data, m_wdata);
      check("mem_wr_mask", 32'(mem_wr_mask), 32'(m_mask));
      check("mem_wr_en", 32'(mem_wr_en), 32'(m_wen));
    end
    check("instr_ack", 32'(instr_ack), 32'(e_iack));
    check("data_ack", 32'(data_ack), 32'(e_dack));
    check("instr_data", instr_data, (m_owner == 1 && hit) ? mem_rd_data : 32'h0);
    check("data_rd_data", data_rd_data, (m_owner == 2 && hit) ? mem_rd_data : 32'h0);
    check("bus_error", 32'(bus_error), 32'(tmo));

    if (m_owner == 0) begin
      if (instr_req && data_req) begin
`ifdef KRONOS_ARB_ROUND_ROBIN_EN
        grant((m_last == 1) ? 2 : 1);
`else
        grant(2);
`endif
      end else if (data_req)  grant(2);
      else if (instr_req)     grant(1);
    end else if (fin) begin
      other  = 3 - m_owner;
      m_last = m_owner;
      if ((other == 1 && instr_req) || (other == 2 && data_req)) grant(other);
      else begin
        m_owner = 0; m_age = 0;
      end
    end else begin
      m_age++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic first_is_data;

  initial begin
    rstz = 1'b0;
    instr_addr = '0; instr_req = 1'b0; data_addr = '0; data_wr_data = '0;
    data_wr_mask = '0; data_wr_en = 1'b0; data_req = 1'b0; mem_ack = 1'b0; mem_rd_data = '0;
    model_reset();
    #2;
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 32'h0);
    check("rst_bus_error", 32'(bus_error), 32'h0);
    @(negedge clk); @(negedge clk);
    rstz = 1'b1;

    // Single fetch, mem_ack two cycles after mem_req rises.
    instr_req = 1'b1; instr_addr = 32'h100;
    step();
    #1 check("fetch_req_rise", 32'(mem_req), 32'h1);
    check("fetch_wr_en", 32'(mem_wr_en), 32'h0);
    step(); step();
    mem_ack = 1'b1; mem_rd_data = 32'h13;
    #1 check("fetch_ack", 32'(instr_ack), 32'h1);
    check("fetch_data", instr_data, 32'h13);
    step();
    instr_req = 1'b0; mem_ack = 1'b0;
    step();

    // Single store.
    data_req = 1'b1; data_addr = 32'h2004; data_wr_data = 32'hDEADBEEF; data_wr_mask = 4'h3; data_wr_en = 1'b1;
    step();
    #1 check("store_addr", mem_addr, 32'h2004);
    check("store_wdata", mem_wr_data, 32'hDEADBEEF);
    check("store_mask", 32'(mem_wr_mask), 32'h3);
    check("store_wen", 32'(mem_wr_en), 32'h1);
    mem_ack = 1'b1; mem_rd_data = 32'h55;
    #1 check("store_ack", 32'(data_ack), 32'h1);
    step();
    data_req = 1'b0; mem_ack = 1'b0;
    step();

    // Timeout: no mem_ack for TIMEOUT grant cycles.
    data_req = 1'b1; data_wr_en = 1'b0; data_addr = 32'h3000;
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    mem_rd_data = 32'hAAAA5555;
    #1 check("tmo_ack", 32'(data_ack), 32'h1);
    check("tmo_rd_data", data_rd_data, 32'h0);
    check("tmo_bus_error", 32'(bus_error), 32'h1);
    step();
    data_req = 1'b0;
    #1 check("tmo_req_drop", 32'(mem_req), 32'h0);
    step();

    // Same, but mem_ack arrives in the last allowed cycle.
    data_req = 1'b1;
    step();
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    mem_ack = 1'b1;
    #1 check("late_ack_no_err", 32'(bus_error), 32'h0);
    check("late_ack_data", data_rd_data, 32'hAAAA5555);
    step();
    data_req = 1'b0; mem_ack = 1'b0;
    step();

    // Simultaneous requests; last owner is data here.
`ifdef KRONOS_ARB_ROUND_ROBIN_EN
    first_is_data = 1'b0;
`else
    first_is_data = 1'b1;
`endif
    instr_req = 1'b1; instr_addr = 32'h400; data_req = 1'b1; data_addr = 32'h5000;
    step();
    #1 check("tie_first", mem_addr, first_is_data ? 32'h5000 : 32'h400);
    mem_ack = 1'b1;
    step();
    if (first_is_data) data_req = 1'b0; else instr_req = 1'b0;
    mem_ack = 1'b0;
    #1 check("b2b_req", 32'(mem_req), 32'h1);
    check("b2b_addr", mem_addr, first_is_data ? 32'h400 : 32'h5000);
    step();
    mem_ack = 1'b1;
    step();
    instr_req = 1'b0; data_req = 1'b0; mem_ack = 1'b0;
    step();

    // mem_ack while IDLE is ignored.
    mem_ack = 1'b1;
    step(); step();
    mem_ack = 1'b0;
    step();

    // Reset in the middle of a data grant.
    data_req = 1'b1; data_addr = 32'h6000; data_wr_data = 32'h12345678; data_wr_mask = 4'hF; data_wr_en = 1'b1;
    step();
    #2 rstz = 1'b0;
    #1 check("rst_mid_req", 32'(mem_req), 32'h0);
    check("rst_mid_addr", mem_addr, 32'h0);
    check("rst_mid_wdata", mem_wr_data, 32'h0);
    check("rst_mid_mask", 32'(mem_wr_mask), 32'h0);
    check("rst_mid_wen", 32'(mem_wr_en), 32'h0);
    check("rst_mid_ack", 32'(data_ack), 32'h0);
    model_reset();
    data_req = 1'b0;
    @(negedge clk);
    rstz = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h700;
    step();
    #1 check("post_rst_grant", mem_addr, 32'h700);
    mem_ack = 1'b1;
    step();
    instr_req = 1'b0; mem_ack = 1'b0;
    step();

    // Randomized requesters and memory.
    for (int c = 0; c < 3000; c++) begin
      if (e_iack) instr_req = 1'b0;
      if (e_dack) data_req = 1'b0;
      if (!instr_req && ($urandom % 2 == 0)) begin
        instr_req = 1'b1; instr_addr = $urandom;
      end
      if (!data_req && ($urandom % 2 == 0)) begin
        data_req = 1'b1; data_addr = $urandom; data_wr_data = $urandom;
        data_wr_mask = 4'($urandom_range(0, 15)); data_wr_en = 1'($urandom % 2);
      end
      mem_ack = ($urandom % 3 == 0);
      mem_rd_data = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
